// File: rtl/soc_bus_interconnect.sv
// soc_bus_interconnect
// Load/store master to NUM_SLAVES peripheral slaves. The top SEL_BITS
// address bits are decoded once in IDLE and registered. Selected slave gets a
// held strobe until it acks. Unmapped indices get an error response.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, an ACCESS phase
// lasting TIMEOUT_CYCLES cycles without an ack ends in an error response.
module soc_bus_interconnect #(
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_BITS       = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             m_read,
  input  logic                             m_write,
  input  logic [2:0]                       m_option,
  input  logic [ADDR_WIDTH-1:0]            m_address,
  input  logic [DATA_WIDTH-1:0]            m_write_data,
  output logic [DATA_WIDTH-1:0]            m_read_data,
  output logic                             m_response,
  output logic                             m_error,
  output logic [NUM_SLAVES-1:0]            s_read,
  output logic [NUM_SLAVES-1:0]            s_write,
  output logic [2:0]                       s_option,
  output logic [ADDR_WIDTH-1:0]            s_address,
  output logic [DATA_WIDTH-1:0]            s_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]            s_ack
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam logic [SEL_BITS:0] LP_NUM_SLAVES = (SEL_BITS+1)'(NUM_SLAVES);

  state_t                  r_state;
  state_t                  w_next_state;

  logic [SEL_BITS-1:0]     r_idx;
  logic                    r_write;
  logic [2:0]              r_option;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [DATA_WIDTH-1:0]   r_write_data;
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic                    r_error;

  logic                    w_req;
  logic [SEL_BITS-1:0]     w_idx;
  logic                    w_mapped;
  logic                    w_ack;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_timeout;
  logic                    w_latch;
  logic                    w_load_rsp;
  logic [DATA_WIDTH-1:0]   w_rsp_data;
  logic                    w_rsp_error;

  assign w_req    = m_read | m_write;
  assign w_idx    = m_address[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_mapped = {1'b0, w_idx} < LP_NUM_SLAVES;

  // Route the selected slave's ack and read data from the latched index
  always_comb begin
    w_ack      = 1'b0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == SEL_BITS'(i)) begin
        w_ack      = s_ack[i];
        w_sel_data = s_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count ACCESS cycles without an ack; cleared whenever a request is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_latch) begin
      r_count <= '0;
    end else if (r_state == ST_ACCESS && !w_ack) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Terminal cycle: this is the TIMEOUT_CYCLES-th ACCESS cycle
  assign w_timeout = (r_state == ST_ACCESS) && (r_count == LP_CNT_LAST);
`else
  // No timer: with a legal TIMEOUT_CYCLES (>=1) this is constant 0
  assign w_timeout = (TIMEOUT_CYCLES < 1);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and response selection; ack takes priority over timeout
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_load_rsp   = 1'b0;
    w_rsp_data   = '0;
    w_rsp_error  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (w_mapped) begin
            w_next_state = ST_ACCESS;
          end else begin
            w_next_state = ST_RESPOND;
            w_load_rsp   = 1'b1;
            w_rsp_data   = ERROR_DATA;
            w_rsp_error  = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (w_ack) begin
          w_next_state = ST_RESPOND;
          w_load_rsp   = 1'b1;
          w_rsp_data   = r_write ? '0 : w_sel_data;
        end else if (w_timeout) begin
          w_next_state = ST_RESPOND;
          w_load_rsp   = 1'b1;
          w_rsp_data   = ERROR_DATA;
          w_rsp_error  = 1'b1;
        end
      end
      ST_RESPOND: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Latch the request fields when IDLE accepts a request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_write      <= 1'b0;
      r_option     <= '0;
      r_address    <= '0;
      r_write_data <= '0;
    end else if (w_latch) begin
      r_idx        <= w_idx;
      r_write      <= m_write;
      r_option     <= m_option;
      r_address    <= m_address;
      r_write_data <= m_write_data;
    end
  end

  // Response data/error: loaded on entry to RESPOND, cleared on its exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data <= '0;
      r_error     <= 1'b0;
    end else if (w_load_rsp) begin
      r_read_data <= w_rsp_data;
      r_error     <= w_rsp_error;
    end else if (r_state == ST_RESPOND) begin
      r_read_data <= '0;
      r_error     <= 1'b0;
    end
  end

  // One-hot strobe to the latched slave, only while in ACCESS
  always_comb begin
    s_read  = '0;
    s_write = '0;
    if (r_state == ST_ACCESS) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (r_idx == SEL_BITS'(i)) begin
          s_read[i]  = ~r_write;
          s_write[i] = r_write;
        end
      end
    end
  end

  assign m_response   = (r_state == ST_RESPOND);
  assign m_read_data  = r_read_data;
  assign m_error      = r_error;
  assign s_option     = r_option;
  assign s_address    = r_address;
  assign s_write_data = r_write_data;

endmodule

// File: tb/tb_soc_bus_interconnect.sv
// Bench for soc_bus_interconnect, built with 3 slaves so the top quarter of
// the address map (index 3) is unmapped. Table vectors, hand sequences for
// timeout/long wait and reset, then randomized transfers against a model.
module tb_soc_bus_interconnect;

  localparam int NS = 3;
  localparam int SB = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m_read, m_write;
  logic [2:0]        m_option;
  logic [AW-1:0]     m_address;
  logic [DW-1:0]     m_write_data;
  logic [DW-1:0]     m_read_data;
  logic              m_response, m_error;
  logic [NS-1:0]     s_read, s_write;
  logic [2:0]        s_option;
  logic [AW-1:0]     s_address;
  logic [DW-1:0]     s_write_data;
  logic [NS*DW-1:0]  s_read_data;
  logic [NS-1:0]     s_ack;
  logic [DW-1:0]     sdat [NS];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [2:0]    opt;
    int            ack_at;   // ACCESS cycle (1-based) of the selected ack, 0 = never
    logic [NS-1:0] spur;     // other slaves acking every cycle
    logic [NS-1:0] exp_sr;
    logic [NS-1:0] exp_sw;
    int            exp_lat;  // cycle after request in which m_response appears
    logic [31:0]   exp_data;
    logic          exp_err;
  } vec_t;

  vec_t tbl [7];

  soc_bus_interconnect #(
    .NUM_SLAVES(NS), .SEL_BITS(SB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO), .ERROR_DATA(ERR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_read(m_read), .m_write(m_write),
    .m_option(m_option), .m_address(m_address), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_response(m_response), .m_error(m_error),
    .s_read(s_read), .s_write(s_write), .s_option(s_option),
    .s_address(s_address), .s_write_data(s_write_data),
    .s_read_data(s_read_data), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  always_comb begin
    s_read_data = '0;
    for (int i = 0; i < NS; i++) s_read_data[i*DW +: DW] = sdat[i];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: expected outcome from the address map and slave behaviour
  function automatic vec_t model(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] opt,
                                 input int ack_at, input logic [NS-1:0] spur);
    vec_t v;
    int idx;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.opt = opt;
    v.ack_at = ack_at; v.spur = spur;
    v.exp_sr = '0; v.exp_sw = '0;
    idx = int'(addr >> (32 - SB));
    if (idx >= NS) begin
      v.exp_lat = 1; v.exp_data = ERR; v.exp_err = 1'b1;
    end else begin
      if (wr) v.exp_sw[idx] = 1'b1; else v.exp_sr[idx] = 1'b1;
      if (ack_at >= 1 && (!TO_EN || ack_at <= TO)) begin
        v.exp_lat = ack_at + 1; v.exp_err = 1'b0;
        v.exp_data = wr ? 32'h0 : sdat[idx];
      end else begin
        v.exp_lat = TO + 1; v.exp_err = 1'b1; v.exp_data = ERR;
      end
    end
    return v;
  endfunction

  // One transfer, starting with the DUT idle, sampled 1 time unit after each edge
  task automatic xfer(input string tag, input vec_t v);
    int strobes = 0;
    logic [NS-1:0] sel;
    sel = v.exp_sr | v.exp_sw;
    m_read = v.rd; m_write = v.wr; m_address = v.addr;
    m_write_data = v.wdata; m_option = v.opt; s_ack = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      if (m_response) begin
        chk({tag, ".latency"}, 64'(cyc), 64'(v.exp_lat));
        chk({tag, ".strobe_cycles"}, 64'(strobes), 64'(v.exp_lat - 1));
        chk({tag, ".rdata"}, m_read_data, v.exp_data);
        chk({tag, ".error"}, m_error, v.exp_err);
        chk({tag, ".strobe_in_respond"}, {s_read, s_write}, '0);
        break;
      end
      if (cyc >= v.exp_lat || cyc == 100) begin
        chk({tag, ".response_due"}, m_response, 1'b1);
        break;
      end
      chk({tag, ".s_read"}, s_read, v.exp_sr);
      chk({tag, ".s_write"}, s_write, v.exp_sw);
      if (sel != '0) begin
        chk({tag, ".s_address"}, s_address, v.addr);
        chk({tag, ".s_write_data"}, s_write_data, v.wdata);
        chk({tag, ".s_option"}, s_option, v.opt);
      end
      if ((s_read | s_write) != '0) strobes++;
      s_ack = (v.spur & ~sel) | ((cyc == v.ack_at) ? sel : '0);
      m_address = $urandom; m_write_data = $urandom; m_option = 3'($urandom);
    end
    m_read = 1'b0; m_write = 1'b0; s_ack = '0;
    @(posedge clk); #1;
    chk({tag, ".idle_after"}, {m_response, s_read, s_write}, '0);
  endtask

  initial begin
    vec_t v;
    int r;
    rst_n = 1'b0; m_read = 1'b0; m_write = 1'b0; m_option = '0;
    m_address = '0; m_write_data = '0; s_ack = '0;
    sdat[0] = 32'h12345678; sdat[1] = 32'h1111AAAA; sdat[2] = 32'h2222BBBB;

    //        rd    wr    addr          wdata        opt   ack spur    sr      sw      lat data          err
    tbl[0] = '{1'b1, 1'b0, 32'h00000010, 32'h0,       3'd2, 1, 3'b000, 3'b001, 3'b000, 2, 32'h12345678, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h80000004, 32'hA5,      3'd1, 3, 3'b000, 3'b000, 3'b100, 4, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'hC0000000, 32'h0,       3'd0, 1, 3'b000, 3'b000, 3'b000, 1, ERR,          1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'h40000020, 32'hCAFE,    3'd5, 2, 3'b100, 3'b000, 3'b010, 3, 32'h0,        1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h40000100, 32'h0,       3'd4, 5, 3'b101, 3'b010, 3'b000, 6, 32'h1111AAAA, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h80000000, 32'h0,       3'd7, 1, 3'b000, 3'b100, 3'b000, 2, 32'h2222BBBB, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'hF0000000, 32'h55,      3'd3, 1, 3'b111, 3'b000, 3'b000, 1, ERR,          1'b1};

    #12;
    chk("reset.outputs", {m_response, m_error, s_read, s_write, s_option}, '0);
    chk("reset.rdata", m_read_data, 32'h0);
    chk("reset.s_address", s_address, 32'h0);
    chk("reset.s_write_data", s_write_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) xfer($sformatf("vec%0d", i), tbl[i]);

`ifdef BUS_TIMEOUT_EN
    v = '{1'b1, 1'b0, 32'h40000008, 32'h0, 3'd0, 0, 3'b000, 3'b010, 3'b000, 16, ERR, 1'b1};
    xfer("timeout_noack", v);
    v = '{1'b1, 1'b0, 32'h40000008, 32'h0, 3'd0, 15, 3'b000, 3'b010, 3'b000, 16, 32'h1111AAAA, 1'b0};
    xfer("timeout_ack_last", v);
    v = '{1'b0, 1'b1, 32'h40000008, 32'h9, 3'd0, 14, 3'b000, 3'b000, 3'b010, 15, 32'h0, 1'b0};
    xfer("timeout_ack_early", v);
`else
    v = '{1'b1, 1'b0, 32'h40000008, 32'h0, 3'd0, 40, 3'b000, 3'b010, 3'b000, 41, 32'h1111AAAA, 1'b0};
    xfer("long_wait", v);
`endif

    for (int n = 0; n < 40; n++) begin
      logic rd, wr;
      int ack_at;
      for (int s = 0; s < NS; s++) sdat[s] = $urandom;
      r  = $urandom_range(1, 3);
      rd = (r != 2);
      wr = (r >= 2);
      ack_at = TO_EN ? $urandom_range(0, 18) : $urandom_range(1, 6);
      v = model(rd, wr, $urandom, $urandom, 3'($urandom), ack_at, NS'($urandom));
      xfer($sformatf("rand%0d", n), v);
    end

    // Reset in the middle of an ACCESS phase
    sdat[1] = 32'h0BADF00D;
    m_read = 1'b1; m_write = 1'b0; m_address = 32'h40000044;
    m_write_data = 32'h77; m_option = 3'd6;
    @(posedge clk); #1;
    chk("rst_mid.strobe_before", s_read, 3'b010);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rst_mid.strobes", {s_read, s_write}, '0);
    chk("rst_mid.resp", {m_response, m_error}, 2'b00);
    chk("rst_mid.rdata", m_read_data, 32'h0);
    chk("rst_mid.s_address", s_address, 32'h0);
    chk("rst_mid.s_wdata_opt", {s_write_data, s_option}, '0);
    m_read = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.held", {m_response, s_read, s_write}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, 32'h40000044, 32'h0, 3'd6, 2, 3'b000, 3'b010, 3'b000, 3, 32'h0BADF00D, 1'b0};
    xfer("post_reset", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
